// File: rtl/contador_desc_pkg.sv
// Shared definitions for the loadable down-counter: FSM state encoding and default width.
`timescale 1ns/1ps
package contador_desc_pkg;

  localparam int DEFAULT_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/contador_desc.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered terminal-count pulse.
`timescale 1ns/1ps
module contador_desc
  import contador_desc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             C,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic             M,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             Z
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             tc_q, tc_d;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    tc_d    = 1'b0;
    if (L) begin
      // Load wins over any expiry on the same edge, so TC stays low.
      q_d     = D;
      r_d     = D;
      state_d = (D != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (C) begin
            if (q_q > ONE) begin
              q_d = q_q - ONE;
            end else if (q_q == ONE) begin
              tc_d = 1'b1;
              if (M) begin
                q_d = r_q;
              end else begin
                q_d     = '0;
                state_d = DONE;
              end
            end else begin
              // Unreachable zero count in RUN: park safely without wrapping.
              state_d = IDLE;
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign TC   = tc_q;
  assign BUSY = (state_q == RUN);
  assign Z    = (state_q == DONE);

endmodule

// File: tb/tb_contador_desc.sv
// Directed self-checking bench for contador_desc using immediate assertions.
`timescale 1ns/1ps
module tb_contador_desc;

  localparam int WIDTH = 10;

  logic             CLK = 1'b0;
  logic             CLR = 1'b1;
  logic             C   = 1'b0;
  logic             L   = 1'b0;
  logic [WIDTH-1:0] D   = '0;
  logic             M   = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             BUSY;
  logic             Z;

  int n_assert = 0;
  int n_fail   = 0;

  contador_desc #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .C   (C),
    .L   (L),
    .D   (D),
    .M   (M),
    .Q   (Q),
    .TC  (TC),
    .BUSY(BUSY),
    .Z   (Z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input int q, input int tc, input int busy, input int z);
    check({tag, ".Q"},    32'(Q),    32'(q));
    check({tag, ".TC"},   32'(TC),   32'(tc));
    check({tag, ".BUSY"}, 32'(BUSY), 32'(busy));
    check({tag, ".Z"},    32'(Z),    32'(z));
  endtask

  initial begin
    int tc_cnt;

    // Reset state
    #2;
    check_all("reset", 0, 0, 0, 0);
    step();
    CLR = 1'b0;
    C = 1'b1;
    step();
    check_all("idle_ignores_c", 0, 0, 0, 0);

    // Mid-count asynchronous clear at Q=5
    C = 1'b0; L = 1'b1; D = 10'd8; M = 1'b0;
    step();
    L = 1'b0; C = 1'b1;
    step(); step(); step();
    check_all("pre_clr", 5, 0, 1, 0);
    #1 CLR = 1'b1;
    #1;
    check_all("async_clr", 0, 0, 0, 0);
    CLR = 1'b0;
    step(); step();
    check_all("post_clr_c", 0, 0, 0, 0);

    // One-shot D=3
    L = 1'b1; D = 10'd3; M = 1'b0; C = 1'b0;
    step();
    check_all("os_load", 3, 0, 1, 0);
    L = 1'b0; C = 1'b1;
    step(); check_all("os_2", 2, 0, 1, 0);
    step(); check_all("os_1", 1, 0, 1, 0);
    step(); check_all("os_0", 0, 1, 0, 1);
    step(); check_all("os_done", 0, 0, 0, 1);

    // Auto-reload D=4 for 12 enabled edges
    L = 1'b1; D = 10'd4; M = 1'b1; C = 1'b0;
    step();
    check_all("ar_load", 4, 0, 1, 0);
    L = 1'b0; C = 1'b1;
    tc_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      tc_cnt += int'(TC);
      check_all($sformatf("ar_%0d", k), 4 - (k % 4), (k % 4 == 0) ? 1 : 0, 1, 0);
    end
    check("ar_tc_count", 32'(tc_cnt), 32'd3);

    // Enable gaps D=2, C = 1,0,1
    L = 1'b1; D = 10'd2; M = 1'b0; C = 1'b0;
    step();
    check_all("gap_load", 2, 0, 1, 0);
    L = 1'b0; C = 1'b1;
    step(); check_all("gap_c1", 1, 0, 1, 0);
    C = 1'b0;
    step(); check_all("gap_c0", 1, 0, 1, 0);
    C = 1'b1;
    step(); check_all("gap_c1b", 0, 1, 0, 1);

    // Mode sampled at expiry: start auto-reload, switch to one-shot before expiry
    L = 1'b1; D = 10'd2; M = 1'b1; C = 1'b0;
    step();
    L = 1'b0; C = 1'b1;
    step(); check_all("msw_1", 1, 0, 1, 0);
    M = 1'b0;
    step(); check_all("msw_exp", 0, 1, 0, 1);

    // Load colliding with expiry, then load of zero
    L = 1'b1; D = 10'd3; M = 1'b0; C = 1'b0;
    step();
    L = 1'b0; C = 1'b1;
    step(); step();
    check_all("col_pre", 1, 0, 1, 0);
    L = 1'b1; D = 10'd7;
    step(); check_all("col_load7", 7, 0, 1, 0);
    D = 10'd0;
    step(); check_all("col_load0", 0, 0, 0, 0);
    L = 1'b0;
    step(); check_all("col_idle", 0, 0, 0, 0);

    // Auto-reload with R=1: TC every enabled edge
    L = 1'b1; D = 10'd1; M = 1'b1; C = 1'b0;
    step();
    L = 1'b0; C = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all($sformatf("r1_%0d", k), 1, 1, 1, 0);
    end

    // Full-width one-shot from 1023
    L = 1'b1; D = 10'd1023; M = 1'b0; C = 1'b0;
    step();
    check_all("w_load", 1023, 0, 1, 0);
    L = 1'b0; C = 1'b1;
    tc_cnt = 0;
    for (int k = 1; k <= 1022; k++) begin
      step();
      tc_cnt += int'(TC);
    end
    check_all("w_1022", 1, 0, 1, 0);
    step();
    tc_cnt += int'(TC);
    check_all("w_1023", 0, 1, 0, 1);
    check("w_tc_count", 32'(tc_cnt), 32'd1);
    step();
    check_all("w_after", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_desc.md
CONTADOR_DESC -- requirements
Module: contador_desc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, giving the counter and load-value width in bits.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 CLR  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 C  input  1  SHALL be the count enable; one decrement per CLK edge while high in RUN.
REQ-005 L  input  1  SHALL be the synchronous load strobe.
REQ-006 D  input  WIDTH  SHALL be the load value, sampled when L=1.
REQ-007 M  input  1  SHALL select the mode: 0 = one-shot, 1 = auto-reload.
REQ-008 Q  output  WIDTH  SHALL be the current count, driven from a register.
REQ-009 TC  output  1  SHALL be the terminal-count pulse, registered and high for exactly one cycle per expiry.
REQ-010 BUSY  output  1  SHALL be high only in state RUN.
REQ-011 Z  output  1  SHALL be the done flag, high only in state DONE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 A hidden WIDTH-bit reload register R SHALL hold the last loaded value.
REQ-014 L=1 SHALL take priority over C in every state.
- Q<=D and R<=D.
- Next state RUN if D!=0, else IDLE.
- TC<=0.
REQ-015 In IDLE or DONE with L=0, C SHALL be ignored and Q SHALL hold.
REQ-016 In RUN with C=0 and L=0, Q, R and state SHALL hold and TC SHALL be 0.
REQ-017 In RUN with C=1, L=0 and Q>1, the block SHALL set Q<=Q-1 with TC<=0.
REQ-018 In RUN with C=1, L=0, Q=1 and M=0, the block SHALL set Q<=0, TC<=1 and next state DONE.
REQ-019 In RUN with C=1, L=0, Q=1 and M=1, the block SHALL set Q<=R, TC<=1 and stay in RUN.
- This gives a period of R cycles of C.
REQ-020 Q SHALL never wrap below 0; no decrement from 0 is possible in any state.
REQ-021 M SHALL be sampled only at the expiry edge; changing M mid-count SHALL affect only the next expiry.
REQ-022 L=1 on the same edge as an expiry SHALL perform the load only, with TC=0 that cycle.
REQ-023 R=1 in auto-reload mode SHALL hold Q=1 and assert TC on every enabled edge.
REQ-024 TC SHALL be 0 on every edge that is not an expiry.

Reset
REQ-025 CLR=1 SHALL immediately force, independent of CLK:
- Q=0 and R=0;
- state IDLE;
- TC=0, BUSY=0, Z=0.
REQ-026 CLR asserted mid-count SHALL abort the count with no TC pulse.
REQ-027 After CLR deasserts, the block SHALL stay in IDLE until L=1.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=00, RUN=01, DONE=10) and the default width constant 10.
REQ-029 The block SHALL be a single module with no sub-module.
- One state register, Q register, R register and TC register.
- Next-state and next-count logic in one combinational process.

Verification
REQ-030 Reset: CLR pulsed mid-count at Q=5 -> Q=0, BUSY=0, Z=0, TC=0 with no clock edge; C=1 afterwards leaves Q=0.
REQ-031 One-shot: L with D=3 and M=0, then C=1 -> Q sequence 3,2,1,0; TC high one cycle coincident with Q=0; Z=1, BUSY=0; further C leaves Q=0.
REQ-032 Auto-reload: D=4, M=1, C held high for 12 cycles -> Q sequence 4,3,2,1,4,3,2,1,...; TC pulses every 4th cycle, 3 pulses total; BUSY stays 1.
REQ-033 Enable gaps: D=2, C toggling 1,0,1 -> Q 2,1,1,0; TC pulses once, only on the final edge.
REQ-034 Collisions: L with D=7 on the edge where Q=1 and C=1 -> Q=7, TC=0, state RUN; L with D=0 -> Q=0, state IDLE, Z=0.
REQ-035 Width edge: D=1023 with WIDTH=10, M=0 -> exactly 1023 enabled edges to Q=0, with a single TC pulse.
